// File: rtl/bcd_operand_entry_pkg.sv
// Shared key codes, FSM state type and digit limits for the decimal operand entry path.
package bcd_operand_entry_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;

    // Largest decimal digit code; anything above is a command or ignored.
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    // Number of decimal digits the entry buffer can hold.
    localparam logic [1:0] MAX_DIGITS = 2'd2;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_operand_entry_bcd2bin.sv
// Combinational two-digit BCD (tens/ones) to binary converter.
module bcd2bin #(
    parameter int unsigned BIN_W = 7
) (
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic [BIN_W-1:0] bin
);

    logic [BIN_W-1:0] tens_ext;
    logic [BIN_W-1:0] ones_ext;

    // tens*10 built from shifts: (tens<<3) + (tens<<1), then add ones.
    always_comb begin
        tens_ext = BIN_W'(tens);
        ones_ext = BIN_W'(ones);
        bin      = (tens_ext << 3) + (tens_ext << 1) + ones_ext;
    end

endmodule

// File: rtl/bcd_operand_entry.sv
// Keypad front end: collects up to two decimal digits, shows them as BCD,
// and on ENTER presents the binary operand over a valid/ready handshake.
module bcd_operand_entry
    import bcd_operand_entry_pkg::*;
#(
    parameter int unsigned BIN_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [3:0]       disp_left,
    output logic [3:0]       disp_right,
    output logic [1:0]       digit_cnt,
    output logic [BIN_W-1:0] value,
    output logic             value_valid,
    input  logic             value_ready,
    output logic             err
);

    state_e           state_q, state_d;
    logic [3:0]       left_q, left_d;
    logic [3:0]       right_q, right_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [BIN_W-1:0] conv_bin;

    bcd2bin #(
        .BIN_W(BIN_W)
    ) u_bcd2bin (
        .tens(left_q),
        .ones(right_q),
        .bin (conv_bin)
    );

    // Next-state decode for the entry FSM, digit shift register and handshake.
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_ENTRY: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (cnt_q < MAX_DIGITS) begin
                            left_d  = right_q;
                            right_d = key_code;
                            cnt_d   = cnt_q + 2'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KEY_ENTER: begin
                                if (cnt_q == 2'd0) begin
                                    err_d = 1'b1;
                                end else begin
                                    value_d = conv_bin;
                                    valid_d = 1'b1;
                                    state_d = ST_HOLD;
                                end
                            end
                            KEY_BKSP: begin
                                if (cnt_q != 2'd0) begin
                                    right_d = left_q;
                                    left_d  = 4'd0;
                                    cnt_d   = cnt_q - 2'd1;
                                end
                            end
                            KEY_CLR: begin
                                left_d  = '0;
                                right_d = '0;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_HOLD: begin
                // Keys are never accepted here, even in the handshake cycle.
                if (key_valid) begin
                    err_d = 1'b1;
                end
                if (valid_q && value_ready) begin
                    valid_d = 1'b0;
                    left_d  = '0;
                    right_d = '0;
                    cnt_d   = '0;
                    state_d = ST_ENTRY;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // State and registered outputs; async reset discards any entry or pending operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ENTRY;
            left_q  <= '0;
            right_q <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign disp_left   = left_q;
    assign disp_right  = right_q;
    assign digit_cnt   = cnt_q;
    assign value       = value_q;
    assign value_valid = valid_q;
    assign err         = err_q;

endmodule
